fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the pipelined MIPS datapath. It owns the PC register, issues instruction reads to the icache side of the datapath/cache interface, and registers each fetched word into the IF/ID latch consumed by the decode unit. It applies decode's `pcSel` redirects (jump, branch, jump-register), absorbs hazard-unit stalls, and freezes permanently on a decoded `HALT`.

## Interface
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `CLK`: in, 1 bit. Single clock; all state updates on the rising edge.
- `nRST`: in, 1 bit. Asynchronous, active-low reset.
- `ihit`: in, 1 bit. The icache returns a valid `imemload` for `imemaddr` this cycle.
- `imemload`: in, 32 bits. Instruction word.
- `imemREN`: out, 1 bit. Instruction read request.
- `imemaddr`: out, 32 bits. Fetch address, always equal to `pc`.
- `stall`: in, 1 bit. Hazard unit holds the PC and the IF/ID latch.
- `pcSel`: in, `pcMux`. Decode's next-PC select for the instruction in IF/ID.
- `halt`: in, 1 bit. Decode flags `HALT` in IF/ID.
- `immJ26`: in, 26 bits. Jump target field from decode.
- `imm16`: in, 16 bits. Branch offset, taken from `ifid_ins[15:0]` by decode.
- `jrAddr`: in, 32 bits. Register value for JR, already forwarded.
- `ifid_ins`: out, 32 bits. Registered instruction.
- `ifid_npc`: out, 32 bits. Registered PC+4 of `ifid_ins`.
- `ifid_valid`: out, 1 bit. IF/ID holds a live instruction.
- `halted`: out, 1 bit. High once the unit is in `FS_HALTED`.

## Operation
- **States:** `FS_RUN`, `FS_REDIRECT_WAIT`, `FS_HALTED`.
- **Combinational outputs:**
  - `imemREN = (state != FS_HALTED)`.
  - `imemaddr = pc`.
  - `halted = (state == FS_HALTED)`.
- **Redirect condition:** `redirect = ifid_valid && !halt && pcSel != PC_NPC`.
- **Redirect targets:**
  - `PC_JUMP`: `{ifid_npc[31:28], immJ26, 2'b00}`.
  - `PC_BR`: `ifid_npc + {{14{imm16[15]}}, imm16, 2'b00}`, modulo 2^32.
  - `PC_JR`: `jrAddr`, used as given with no alignment check.
  - Any other value: treated as `PC_NPC`.
- **`FS_RUN` updates, highest priority first:**
  1. `ifid_valid && halt && !stall`: go to `FS_HALTED`; `ifid_valid` <= 0; `pc` holds.
  2. `stall`: `pc`, the IF/ID latch and the state all hold. An `ihit` in this cycle is discarded and the same address is refetched later.
  3. `redirect && ihit`: `pc` <= target; `ifid_valid` <= 0. The fetched word is squashed; there is no delay slot.
  4. `redirect && !ihit`: `pending` <= target; go to `FS_REDIRECT_WAIT`; `ifid_valid` <= 0; `pc` holds. `imemaddr` must not change while a miss is outstanding.
  5. `ihit`: `pc` <= `pc+4`; `ifid_ins` <= `imemload`; `ifid_npc` <= `pc+4`; `ifid_valid` <= 1.
  6. Otherwise: `ifid_valid` <= 0 (bubble); `pc` holds.
- **`FS_REDIRECT_WAIT`:**
  - `imemaddr` stays at the old `pc`.
  - On `ihit`: discard the word, `pc` <= `pending`, go to `FS_RUN`.
  - `stall` is ignored in this state, because IF/ID is already empty.
- **`FS_HALTED`:** absorbing; only `nRST` leaves it. `imemREN` = 0. IF/ID is frozen with `ifid_valid` = 0.
- **Reset values:**
  - `pc = PC_INIT`, `pending = 0`, `ifid_ins = 0`, `ifid_npc = 0`, `ifid_valid = 0`, state `FS_RUN`.
  - Hence `imemREN = 1` and `imemaddr = PC_INIT` while `nRST` is low.
- **Reset mid-operation:** any outstanding miss or pending redirect is dropped.

## Timing
- Fetch-to-IF/ID latency: 1 edge after `ihit`. With continuous hits, throughput is 1 instruction per cycle.
- Redirect penalty:
  - 1 bubble cycle when the redirecting cycle hits.
  - 1 + (remaining miss cycles) + 1 when it misses.
- `stall` has no effect on the address. It is a full hold of the PC and IF/ID; no partial update is allowed.
- `halt` and `redirect` are mutually exclusive by construction, and `halt` wins if both are presented.

## Structure
- `pcMux` (`PC_NPC`, `PC_JUMP`, `PC_BR`, `PC_JR`) is reused from `mux_types_pkg`.
- `fetch_state_t` is added to `cpu_types_pkg` beside `word_t`.
- Sub-module `pc_target_calc`: purely combinational. Inputs are `pcSel`, `ifid_npc`, `immJ26`, `imm16`, `jrAddr`; output is the 32-bit target. The branch adder lives here.

## Test plan
- **Reset and straight-line fetch:**
  - Stimulus: `PC_INIT=0`, `ihit` tied high, memory holds words 0x0..0xC.
  - Response: `imemaddr` steps 0,4,8,C; `ifid_npc` steps 4,8,C,10; `ifid_valid` rises 1 edge after the release of `nRST`.
- **Miss bubbles:**
  - Stimulus: `ihit` low for 3 cycles at `pc` = 8.
  - Response: `imemaddr` holds 8; 3 cycles with `ifid_valid` = 0; then `ifid_ins` = the word at 8 and `ifid_npc` = C.
- **Branch taken with a hit:**
  - Stimulus: IF/ID holds `ifid_npc` = 0x14, `pcSel` = `PC_BR`, `imm16` = 0xFFFE.
  - Response: next `pc` = 0x0C; the fetched word is squashed; 1 bubble.
- **JR during a miss:**
  - Stimulus: `jrAddr` = 0x40 while `ihit` = 0 for 2 cycles.
  - Response: state `FS_REDIRECT_WAIT`; `imemaddr` stays at the old pc until `ihit`; then `pc` = 0x40 and `ifid_valid` = 0 throughout.
- **Stall priority:**
  - Stimulus: `stall` = 1 together with a JUMP in IF/ID and `ihit` = 1.
  - Response: `pc` and IF/ID unchanged. The jump is taken on the first cycle with `stall` = 0: target `{npc[31:28], immJ26, 00}`.
- **Halt:**
  - Stimulus: `halt` = 1 with `ifid_valid` = 1.
  - Response: next cycle `halted` = 1, `imemREN` = 0, `ifid_valid` = 0; the unit stays halted under further `ihit` and `stall` activity; asserting `nRST` restores `pc` to `PC_INIT`.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Core CPU datapath types, including the fetch-stage state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FS_RUN           = 2'd0,
    FS_REDIRECT_WAIT = 2'd1,
    FS_HALTED        = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mux_types_pkg.sv
// Datapath mux select encodings shared across pipeline stages.
package mux_types_pkg;

  typedef enum logic [1:0] {
    PC_NPC  = 2'd0,
    PC_JUMP = 2'd1,
    PC_BR   = 2'd2,
    PC_JR   = 2'd3
  } pcMux;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target for decode redirects (jump, branch, jump-register).
module pc_target_calc
  import mux_types_pkg::*;
(
  input  pcMux        pcSel,
  input  logic [31:0] ifid_npc,
  input  logic [25:0] immJ26,
  input  logic [15:0] imm16,
  input  logic [31:0] jrAddr,
  output logic [31:0] target
);

  logic [31:0] w_br_offset;

  assign w_br_offset = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    target = ifid_npc;
    case (pcSel)
      PC_JUMP: target = {ifid_npc[31:28], immJ26, 2'b00};
      PC_BR:   target = ifid_npc + w_br_offset;
      PC_JR:   target = jrAddr;
      default: target = ifid_npc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, icache request, IF/ID latch, redirects,
// stall hold and permanent halt.
module fetch_unit
  import mux_types_pkg::*;
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  pcMux        pcSel,
  input  logic        halt,
  input  logic [25:0] immJ26,
  input  logic [15:0] imm16,
  input  logic [31:0] jrAddr,
  output logic [31:0] ifid_ins,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_t r_state;
  word_t        r_pc;
  word_t        r_pending;
  word_t        r_ifid_ins;
  word_t        r_ifid_npc;
  logic         r_ifid_valid;

  word_t        w_target;
  word_t        w_pc_plus4;
  logic         w_redirect;

  pc_target_calc u_target (
    .pcSel    (pcSel),
    .ifid_npc (r_ifid_npc),
    .immJ26   (immJ26),
    .imm16    (imm16),
    .jrAddr   (jrAddr),
    .target   (w_target)
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = r_ifid_valid && !halt && (pcSel != PC_NPC);

  assign imemREN    = (r_state != FS_HALTED);
  assign imemaddr   = r_pc;
  assign halted     = (r_state == FS_HALTED);
  assign ifid_ins   = r_ifid_ins;
  assign ifid_npc   = r_ifid_npc;
  assign ifid_valid = r_ifid_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= FS_RUN;
      r_pc         <= PC_INIT;
      r_pending    <= '0;
      r_ifid_ins   <= '0;
      r_ifid_npc   <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        FS_RUN: begin
          // Halt only commits once the hazard unit releases the stage.
          if (r_ifid_valid && halt && !stall) begin
            r_state      <= FS_HALTED;
            r_ifid_valid <= 1'b0;
          end else if (stall) begin
            r_state <= FS_RUN;
          end else if (w_redirect && ihit) begin
            r_pc         <= w_target;
            r_ifid_valid <= 1'b0;
          end else if (w_redirect) begin
            // Miss outstanding: keep imemaddr stable and remember where to go.
            r_pending    <= w_target;
            r_state      <= FS_REDIRECT_WAIT;
            r_ifid_valid <= 1'b0;
          end else if (ihit) begin
            r_pc         <= w_pc_plus4;
            r_ifid_ins   <= imemload;
            r_ifid_npc   <= w_pc_plus4;
            r_ifid_valid <= 1'b1;
          end else begin
            r_ifid_valid <= 1'b0;
          end
        end
        FS_REDIRECT_WAIT: begin
          if (ihit) begin
            r_pc    <= r_pending;
            r_state <= FS_RUN;
          end
        end
        FS_HALTED: begin
          r_state <= FS_HALTED;
        end
        default: begin
          r_state      <= FS_RUN;
          r_ifid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed per-cycle stimulus pushes expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_fetch_unit;
  import mux_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  pcMux        pcSel;
  logic        halt;
  logic [25:0] immJ26;
  logic [15:0] imm16;
  logic [31:0] jrAddr;
  logic [31:0] ifid_ins;
  logic [31:0] ifid_npc;
  logic        ifid_valid;
  logic        halted;

  typedef struct {
    int          stepno;
    logic        v;
    logic [31:0] ins;
    logic [31:0] npc;
    logic [31:0] addr;
    logic        ren;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;
  int   stepcnt;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ihit       (ihit),
    .imemload   (imemload),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .stall      (stall),
    .pcSel      (pcSel),
    .halt       (halt),
    .immJ26     (immJ26),
    .imm16      (imm16),
    .jrAddr     (jrAddr),
    .ifid_ins   (ifid_ins),
    .ifid_npc   (ifid_npc),
    .ifid_valid (ifid_valid),
    .halted     (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input int s, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, s, act, exp);
    end
  endtask

  // Drive one cycle of inputs, record the state expected after the next edge.
  task automatic step(input logic ih, input logic st, input logic hl,
                      input pcMux sel, input logic [31:0] load,
                      input logic ev, input logic [31:0] eins,
                      input logic [31:0] enpc, input logic [31:0] eaddr,
                      input logic eren, input logic ehlt);
    exp_t e;
    ihit     = ih;
    stall    = st;
    halt     = hl;
    pcSel    = sel;
    imemload = load;
    stepcnt++;
    e.stepno = stepcnt;
    e.v      = ev;
    e.ins    = eins;
    e.npc    = enpc;
    e.addr   = eaddr;
    e.ren    = eren;
    e.hlt    = ehlt;
    sb.push_back(e);
    @(negedge CLK);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ifid_valid", e.stepno, {31'd0, ifid_valid}, {31'd0, e.v});
        chk("imemaddr",   e.stepno, imemaddr, e.addr);
        chk("imemREN",    e.stepno, {31'd0, imemREN}, {31'd0, e.ren});
        chk("halted",     e.stepno, {31'd0, halted}, {31'd0, e.hlt});
        if (e.v) begin
          chk("ifid_ins", e.stepno, ifid_ins, e.ins);
          chk("ifid_npc", e.stepno, ifid_npc, e.npc);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    tests    = 0;
    fails    = 0;
    stepcnt  = 0;
    nRST     = 1'b0;
    ihit     = 1'b0;
    stall    = 1'b0;
    halt     = 1'b0;
    pcSel    = PC_NPC;
    imemload = '0;
    immJ26   = '0;
    imm16    = '0;
    jrAddr   = '0;
    @(negedge CLK);

    // Reset held: fetch request already up at PC_INIT
    step(1, 0, 0, PC_NPC, mw(32'h0), 0, 0, 0, 32'h0, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h0), 0, 0, 0, 32'h0, 1, 0);
    nRST = 1'b1;

    // Straight-line fetch
    step(1, 0, 0, PC_NPC, mw(32'h0), 1, mw(32'h0), 32'h4, 32'h4, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h4), 1, mw(32'h4), 32'h8, 32'h8, 1, 0);

    // Three-cycle miss at pc=8
    step(0, 0, 0, PC_NPC, 32'h0, 0, 0, 0, 32'h8, 1, 0);
    step(0, 0, 0, PC_NPC, 32'h0, 0, 0, 0, 32'h8, 1, 0);
    step(0, 0, 0, PC_NPC, 32'h0, 0, 0, 0, 32'h8, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h8),  1, mw(32'h8),  32'hC,  32'hC,  1, 0);
    step(1, 0, 0, PC_NPC, mw(32'hC),  1, mw(32'hC),  32'h10, 32'h10, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h10), 1, mw(32'h10), 32'h14, 32'h14, 1, 0);

    // Backward branch with hit: 0x14 - 8 = 0x0C, one bubble
    imm16 = 16'hFFFE;
    step(1, 0, 0, PC_BR,  mw(32'h14), 0, 0, 0, 32'hC, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'hC),  1, mw(32'hC), 32'h10, 32'h10, 1, 0);

    // JR during a miss; later jrAddr changes and stall must not matter
    jrAddr = 32'h40;
    step(0, 0, 0, PC_JR, 32'h0, 0, 0, 0, 32'h10, 1, 0);
    jrAddr = 32'h80;
    step(0, 0, 0, PC_JR, 32'h0, 0, 0, 0, 32'h10, 1, 0);
    step(1, 1, 0, PC_JR, mw(32'h10), 0, 0, 0, 32'h40, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h40), 1, mw(32'h40), 32'h44, 32'h44, 1, 0);

    // Stall holds everything despite JUMP and ihit; jump taken once released
    immJ26 = 26'h000_0050;
    step(1, 1, 0, PC_JUMP, mw(32'h44), 1, mw(32'h40), 32'h44, 32'h44, 1, 0);
    step(1, 1, 0, PC_JUMP, mw(32'h44), 1, mw(32'h40), 32'h44, 32'h44, 1, 0);
    step(1, 0, 0, PC_JUMP, mw(32'h44), 0, 0, 0, 32'h140, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h140), 1, mw(32'h140), 32'h144, 32'h144, 1, 0);

    // JR with hit to a high region, then jump keeping npc[31:28]
    jrAddr = 32'h3000_0100;
    step(1, 0, 0, PC_JR, mw(32'h144), 0, 0, 0, 32'h3000_0100, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h3000_0100), 1, mw(32'h3000_0100),
         32'h3000_0104, 32'h3000_0104, 1, 0);
    immJ26 = 26'h3FF_FFFF;
    step(1, 0, 0, PC_JUMP, mw(32'h3000_0104), 0, 0, 0, 32'h3FFF_FFFC, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h3FFF_FFFC), 1, mw(32'h3FFF_FFFC),
         32'h4000_0000, 32'h4000_0000, 1, 0);

    // Forward branch: 0x4000_0000 + 0x10
    imm16 = 16'h0004;
    step(1, 0, 0, PC_BR, mw(32'h4000_0000), 0, 0, 0, 32'h4000_0010, 1, 0);
    step(1, 0, 0, PC_NPC, mw(32'h4000_0010), 1, mw(32'h4000_0010),
         32'h4000_0014, 32'h4000_0014, 1, 0);

    // Halt: stalled first (hold), then commits and wins over a branch
    step(1, 1, 1, PC_BR, mw(32'h4000_0014), 1, mw(32'h4000_0010),
         32'h4000_0014, 32'h4000_0014, 1, 0);
    step(1, 0, 1, PC_BR,  mw(32'h4000_0014), 0, 0, 0, 32'h4000_0014, 0, 1);
    step(1, 1, 0, PC_JR,  mw(32'h4000_0014), 0, 0, 0, 32'h4000_0014, 0, 1);
    step(1, 0, 0, PC_NPC, mw(32'h4000_0014), 0, 0, 0, 32'h4000_0014, 0, 1);
    step(0, 0, 1, PC_NPC, 32'h0,             0, 0, 0, 32'h4000_0014, 0, 1);

    // Reset leaves the halted state and restores PC_INIT
    nRST = 1'b0;
    step(1, 0, 0, PC_NPC, mw(32'h0), 0, 0, 0, 32'h0, 1, 0);
    nRST = 1'b1;
    step(1, 0, 0, PC_NPC, mw(32'h0), 1, mw(32'h0), 32'h4, 32'h4, 1, 0);

    repeat (2) @(negedge CLK);
    chk("scoreboard_drained", 0, sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
